// File: rtl/fp_exec_unit.sv
// Multi-cycle IEEE-754 binary32 execute unit for the RV32 Execute stage.
// FADD/FSUB/FMUL take three cycles and FDIV is a one-bit-per-cycle restoring divide; all results are truncated.
module fp_exec_unit #(
  parameter int DIV_BITS = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [1:0]  FpOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic        BusyE,
  output logic        DoneE,
  output logic [31:0] FpResultE
);

  typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

  localparam logic [31:0] QNAN  = 32'h7FC0_0000;
  localparam logic [30:0] INF31 = 31'h7F80_0000;

  state_t                state, state_nxt;
  logic [1:0]            op;
  logic                  sign_a, sign_b;
  logic [7:0]            exp_a, exp_b;
  logic [23:0]           man_a, man_b;
  logic                  spec_hit;
  logic [31:0]           spec_val;
  logic [25:0]           rem;
  logic [DIV_BITS-1:0]   quo;
  logic [4:0]            cnt;

  // Launch-time unpack and special-case classification
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sb_eff, s_md;
  logic spec_hit_l;
  logic [31:0] spec_val_l;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    a_zero     = (SrcAE[30:23] == 8'h00);
    a_inf      = (SrcAE[30:23] == 8'hFF) && (SrcAE[22:0] == 23'h0);
    a_nan      = (SrcAE[30:23] == 8'hFF) && (SrcAE[22:0] != 23'h0);
    b_zero     = (SrcBE[30:23] == 8'h00);
    b_inf      = (SrcBE[30:23] == 8'hFF) && (SrcBE[22:0] == 23'h0);
    b_nan      = (SrcBE[30:23] == 8'hFF) && (SrcBE[22:0] != 23'h0);
    sb_eff     = SrcBE[31] ^ (FpOpE == 2'b01);
    s_md       = SrcAE[31] ^ SrcBE[31];
    spec_hit_l = 1'b1;
    spec_val_l = QNAN;
    if (!(a_nan || b_nan)) begin
      case (FpOpE)
        2'b10: begin
          if ((a_zero && b_inf) || (a_inf && b_zero)) spec_val_l = QNAN;
          else if (a_inf || b_inf)                    spec_val_l = {s_md, INF31};
          else if (a_zero || b_zero)                  spec_val_l = {s_md, 31'h0};
          else                                        spec_hit_l = 1'b0;
        end
        2'b11: begin
          if ((a_zero && b_zero) || (a_inf && b_inf)) spec_val_l = QNAN;
          else if (a_inf || b_zero)                   spec_val_l = {s_md, INF31};
          else if (a_zero || b_inf)                   spec_val_l = {s_md, 31'h0};
          else                                        spec_hit_l = 1'b0;
        end
        default: begin
          if (a_inf && b_inf && (SrcAE[31] != sb_eff)) spec_val_l = QNAN;
          else if (a_inf)                              spec_val_l = {SrcAE[31], INF31};
          else if (b_inf)                              spec_val_l = {sb_eff, INF31};
          else                                         spec_hit_l = 1'b0;
        end
      endcase
    end
  end

  function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e,
                                       input logic [22:0] f);
    if (e > 10'sd254)   return {s, 31'h7F7F_FFFF};
    else if (e < 10'sd1) return {s, 31'h0};
    else                 return {s, e[7:0], f};
  endfunction

  // Add/sub: align smaller operand with guard/round/sticky, then normalise by leading one
  logic               a_big, big_s, sml_s;
  logic [7:0]         big_e, sml_e, d;
  logic [23:0]        big_m, sml_m;
  logic [49:0]        sml_sh;
  logic [26:0]        sml_al;
  logic [27:0]        sum;
  logic [4:0]         lead;
  logic signed [9:0]  add_e;
  logic [31:0]        add_res;

  always_comb begin
    a_big  = {exp_a, man_a} >= {exp_b, man_b};
    big_s  = a_big ? sign_a : sign_b;
    sml_s  = a_big ? sign_b : sign_a;
    big_e  = a_big ? exp_a : exp_b;
    sml_e  = a_big ? exp_b : exp_a;
    big_m  = a_big ? man_a : man_b;
    sml_m  = a_big ? man_b : man_a;
    d      = big_e - sml_e;
    sml_sh = {sml_m, 26'h0} >> d;
    if (d > 8'd26) sml_al = {26'h0, |sml_m};
    else           sml_al = {sml_sh[49:24], |sml_sh[23:0]};
    if (big_s == sml_s) sum = {1'b0, big_m, 3'b000} + {1'b0, sml_al};
    else                sum = {1'b0, big_m, 3'b000} - {1'b0, sml_al};
    lead = 5'd0;
    for (int i = 0; i < 28; i++) if (sum[i]) lead = 5'(i);
    add_e = 10'(big_e) + 10'(lead) - 10'd26;
    if (sum == 28'h0) add_res = {(big_s == sml_s) ? big_s : 1'b0, 31'h0};
    else              add_res = pack(big_s, add_e, 23'((sum << (5'd27 - lead)) >> 4));
  end

  // Multiply: 48-bit significand product, leading one at bit 47 or 46
  logic [47:0]       prod;
  logic signed [9:0] mul_e;
  logic [31:0]       mul_res;

  always_comb begin
    prod    = man_a * man_b;
    mul_e   = 10'(exp_a) + 10'(exp_b) - 10'd127 + 10'(prod[47]);
    mul_res = pack(sign_a ^ sign_b, mul_e, prod[47] ? 23'(prod >> 24) : 23'(prod >> 23));
  end

  // Divide: one restoring step per DIV cycle; final quotient in [0.5, 2)
  logic                ge;
  logic [25:0]         rem_nxt;
  logic [DIV_BITS-1:0] quo_nxt;
  logic signed [9:0]   div_e;
  logic [31:0]         div_res;

  always_comb begin
    ge      = rem >= {2'b00, man_b};
    rem_nxt = (ge ? rem - {2'b00, man_b} : rem) << 1;
    quo_nxt = {quo[DIV_BITS-2:0], ge};
    div_e   = 10'(exp_a) - 10'(exp_b) + 10'd126 + 10'(quo_nxt[DIV_BITS-1]);
    div_res = pack(sign_a ^ sign_b, div_e,
                   quo_nxt[DIV_BITS-1] ? 23'(quo_nxt >> (DIV_BITS - 24)) : 23'(quo_nxt >> (DIV_BITS - 25)));
  end

  logic [31:0] res;

  always_comb begin
    case (op)
      2'b10:   res = mul_res;
      2'b11:   res = div_res;
      default: res = add_res;
    endcase
    if (spec_hit) res = spec_val;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (StartE) state_nxt = (FpOpE == 2'b11) ? DIV : EXEC;
      EXEC: state_nxt = DONE;
      DIV:  if (cnt == 5'(DIV_BITS - 1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign BusyE = (state == EXEC) || (state == DIV) || ((state == IDLE) && StartE);
  assign DoneE = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op        <= 2'b00;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      exp_a     <= 8'h0;
      exp_b     <= 8'h0;
      man_a     <= 24'h0;
      man_b     <= 24'h0;
      spec_hit  <= 1'b0;
      spec_val  <= 32'h0;
      rem       <= 26'h0;
      quo       <= '0;
      cnt       <= 5'd0;
      FpResultE <= 32'h0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && StartE) begin
        op       <= FpOpE;
        sign_a   <= SrcAE[31];
        sign_b   <= sb_eff;
        exp_a    <= a_zero ? 8'h0 : SrcAE[30:23];
        exp_b    <= b_zero ? 8'h0 : SrcBE[30:23];
        man_a    <= a_zero ? 24'h0 : {1'b1, SrcAE[22:0]};
        man_b    <= b_zero ? 24'h0 : {1'b1, SrcBE[22:0]};
        spec_hit <= spec_hit_l;
        spec_val <= spec_val_l;
        rem      <= a_zero ? 26'h0 : {3'b001, SrcAE[22:0]};
        quo      <= '0;
        cnt      <= 5'd0;
      end
      if (state == DIV) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + 5'd1;
      end
      if ((state_nxt == DONE) && (state != DONE)) FpResultE <= res;
    end
  end

endmodule

// File: doc/fp_exec_unit.md
# fp_exec_unit

Multi-cycle single-precision floating-point execute unit in the Execute stage of the pipelined RV32 core. It consumes the decoder's FP flag and 2-bit FP operation once both have been registered into Execute, and computes FADD.S, FSUB.S, FMUL.S or FDIV.S on the two forwarded source operands. It holds the hazard unit in stall through `BusyE` until the result is ready. It then presents the result for one cycle alongside `DoneE` so that Execute→Memory can capture it.

## Interface
- `DIV_BITS`, default 25: quotient bits produced by the iterative divider, one per cycle.
- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `StartE` input 1: launch request, equal to `IsFpE` of a valid instruction in Execute.
- `FpOpE` input 2: operation select.
  - 00: add
  - 01: sub
  - 10: mul
  - 11: div
- `SrcAE` input 32: operand A, IEEE-754 binary32.
- `SrcBE` input 32: operand B, IEEE-754 binary32.
- `BusyE` output 1: stall request to the hazard unit.
- `DoneE` output 1: one-cycle pulse; `FpResultE` is valid in this cycle.
- `FpResultE` output 32: result register; holds its value until the next `DoneE`.

## Operation
- FSM states are IDLE, EXEC, DIV and DONE.
  - IDLE with `StartE`=1: latch the unpacked operands and `FpOpE`. Go to EXEC for ops 00/01/10, or to DIV for op 11.
  - EXEC: compute and normalise the add/sub/mul result, then go to DONE.
  - DIV: restoring divide of the 24-bit significands, one quotient bit per cycle. A 5-bit iteration counter runs 0..DIV_BITS-1. On the last bit, normalise and go to DONE.
  - DONE: `DoneE`=1, then go to IDLE unconditionally.
- `StartE` is ignored outside IDLE. A new instruction may start in the cycle directly after DONE.
- `BusyE` = (state≠IDLE and state≠DONE) or (state==IDLE and `StartE`). It is combinational on `StartE` in the launch cycle.
- `FpResultE` is loaded only on the transition into DONE.
- Unpacking:
  - Hidden bit is 1 for exponent 1..254.
  - Exponent 0 is treated as zero; subnormal inputs flush to a signed zero.
  - Exponent 255 with mantissa 0 is ±inf; exponent 255 with mantissa ≠0 is NaN.
- Rounding is round-toward-zero only.
  - Add/sub keep guard, round and sticky bits through alignment, so subtraction truncates the exact result. Example: 1.0 − 2^-30 → 0x3F7FFFFF.
  - Mul truncates the 48-bit product after normalisation.
  - Div truncates the quotient.
- Sub is add with B's sign inverted.
- Mul/div result sign is the XOR of the operand signs.
- An exact-zero add/sub result is +0, except (−0)+(−0), which gives −0.
- Special cases, checked at launch, go to the normal DONE timing for their op:
  - Any NaN input, inf−inf, 0×inf, 0/0 and inf/inf → 0x7FC00000.
  - Finite nonzero / 0 → signed inf.
  - Any other inf operand → signed inf. x/inf → signed zero.
- Overflow (biased exponent >254 after normalisation) → signed 0x7F7FFFFF.
- Underflow (biased exponent <1) → signed zero.
- No exception flags are produced.

## Timing
- The launch cycle (IDLE with `StartE`) is cycle 0.
- Add/sub/mul: EXEC in cycle 1, DONE in cycle 2. `BusyE` is high in cycles 0–1.
- Div: DIV in cycles 1..DIV_BITS (1..25), DONE in cycle 26. `BusyE` is high in cycles 0–25.
- `BusyE` is low in the DONE cycle, so the stalled Execute instruction advances on that edge with `FpResultE`.
- Reset, asserted at any time including mid-divide:
  - state goes to IDLE and the iteration counter to 0;
  - `BusyE`=0 (when `StartE`=0), `DoneE`=0, `FpResultE`=0x00000000.
- `StartE` held continuously gives back-to-back operations: DONE → IDLE → launch. Each operation re-samples its operands at launch.

## Test plan
- 0x3FC00000 + 0x40100000 (1.5+2.25), op 00 → `BusyE` high in cycles 0–1; `DoneE` and `FpResultE`=0x40700000 in cycle 2.
- 0x3F800000 − 0x3F800000, op 01 → 0x00000000. Then 0x3F800000 − 0x30800000 → 0x3F7FFFFF.
- 0x40400000 × 0xBF000000 (3.0 × −0.5), op 10 → 0xBFC00000 in cycle 2. Then 0x7F000000 × 0x40000000 → 0x7F7FFFFF.
- 0x3F800000 / 0x40400000 (1/3), op 11 → `BusyE` high in cycles 0–25; `DoneE` in cycle 26 with 0x3EAAAAAA.
- Special cases:
  - 0x3F800000 / 0x00000000 → 0x7F800000 at cycle 26.
  - 0x00000000 / 0x00000000 → 0x7FC00000.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000 at cycle 2.
- Divide launched and reset asserted asynchronously at cycle 10:
  - `BusyE`/`DoneE`=0 and `FpResultE`=0 immediately, with no `DoneE` afterwards.
  - After release, a new add launches and completes at cycle 2 with the correct result.
  - `StartE` pulsed while busy is ignored.
